// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// No logic; imported by the top level.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder; the only place the sum/carry equations live.
// Purely combinational: zero latency, no flow control.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// LSB-first serial adder: result and done pulse WIDTH cycles after an accepted start.
// No backpressure; start is only sampled while idle and is dropped (not queued) while busy.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_cat;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Partial sum is kept one bit short: this cycle's bit completes it at the MSB end.
    generate
        if (WIDTH == 1) begin : g_one
            assign sum_cat = fa_s;
        end else begin : g_multi
            logic [WIDTH-2:0] sum_sr;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sum_sr <= '0;
                end else if (state == ADD) begin
                    sum_sr <= sum_cat[WIDTH-1:1];
                end
            end
            assign sum_cat = {fa_s, sum_sr};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= input1;
                        b_sr  <= input2;
                        c_reg <= carry_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    c_reg <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum       <= sum_cat;
                        carry_out <= fa_cout;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] input1;
    logic [7:0] input2;
    logic       carry_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .input1    (input1),
        .input2    (input2),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .input1    (a1),
        .input2    (b1),
        .carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic s;
        logic c;
    } vec1_t;

    vec8_t vecs[6];
    vec1_t tt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts one WIDTH=8 addition and checks latency, busy length, result and sum stability.
    task automatic run_add8(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic [7:0] es, input logic ec);
        int cycles;
        int busy_cnt;
        logic [7:0] sum_before;
        logic       cout_before;
        logic       unstable;
        sum_before  = sum;
        cout_before = carry_out;
        unstable    = 1'b0;
        input1   = a;
        input2   = b;
        carry_in = cin;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        input1   = 8'hxx;
        input2   = 8'hxx;
        carry_in = 1'bx;
        check({name, "_busy_after_start"}, 32'(busy), 32'd1);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (sum !== sum_before || carry_out !== cout_before) unstable = 1'b1;
            tick();
            cycles++;
        end
        check({name, "_latency"}, 32'(cycles), 32'd8);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({name, "_stable_while_busy"}, 32'(unstable), 32'd0);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(carry_out), 32'(ec));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cycles;
        int ndone;
        int done_at;

        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, c: 1'b1};
        vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0};
        vecs[4] = '{a: 8'hC8, b: 8'h64, cin: 1'b0, s: 8'h2C, c: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h7F, cin: 1'b1, s: 8'h00, c: 1'b1};

        tt[0] = '{a: 0, b: 0, cin: 0, s: 0, c: 0};
        tt[1] = '{a: 0, b: 0, cin: 1, s: 1, c: 0};
        tt[2] = '{a: 0, b: 1, cin: 0, s: 1, c: 0};
        tt[3] = '{a: 0, b: 1, cin: 1, s: 0, c: 1};
        tt[4] = '{a: 1, b: 0, cin: 0, s: 1, c: 0};
        tt[5] = '{a: 1, b: 0, cin: 1, s: 0, c: 1};
        tt[6] = '{a: 1, b: 1, cin: 0, s: 0, c: 1};
        tt[7] = '{a: 1, b: 1, cin: 1, s: 1, c: 1};

        reset = 1'b1; start = 1'b0; input1 = '0; input2 = '0; carry_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        check("rst_busy_w1", 32'(busy1), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_add8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].s, vecs[i].c);
        end

        // start re-asserted mid-operation must be ignored
        input1 = 8'h3C; input2 = 8'h11; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 1 && c <= 4) begin
                start = 1'b1; input1 = 8'hFF; input2 = 8'hFF; carry_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
        end
        check("ignore_start_ndone", 32'(ndone), 32'd1);
        check("ignore_start_latency", 32'(done_at), 32'd8);
        check("ignore_start_sum", 32'(sum), 32'h4D);
        check("ignore_start_cout", 32'(carry_out), 32'd0);
        check("ignore_start_idle", 32'(busy), 32'd0);

        // start held through the done cycle: second add accepted at the following edge
        input1 = 8'h0F; input2 = 8'h01; carry_in = 1'b0; start = 1'b1;
        tick();
        input1 = 8'h80; input2 = 8'h80;
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        check("b2b_first_latency", 32'(cycles), 32'd8);
        check("b2b_first_sum", 32'(sum), 32'h10);
        check("b2b_first_cout", 32'(carry_out), 32'd0);
        tick();
        start = 1'b0;
        check("b2b_second_accepted", 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        check("b2b_second_latency", 32'(cycles), 32'd8);
        check("b2b_second_sum", 32'(sum), 32'h00);
        check("b2b_second_cout", 32'(carry_out), 32'd1);
        tick();

        // reset mid-operation aborts without a done pulse
        input1 = 8'hFF; input2 = 8'hFF; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(carry_out), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_late_done", 32'(ndone), 32'd0);
        run_add8("after_abort", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            a1 = tt[i].a; b1 = tt[i].b; cin1 = tt[i].cin; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("w1_busy_%0d", i), 32'(busy1), 32'd1);
            tick();
            check($sformatf("w1_done_%0d", i), 32'(done1), 32'd1);
            check($sformatf("w1_sum_%0d", i), 32'(sum1), 32'(tt[i].s));
            check($sformatf("w1_cout_%0d", i), 32'(cout1), 32'(tt[i].c));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
